bp_cce_lce_req_receiver: RTL

CCE-side receiver for BedRock LCE request messages, the consuming end of the LCE request channel.
- Buffers incoming requests, checks that they are routed to this CCE, decodes them and presents one request at a time to the CCE core over valid/yumi.
- For uncached stores, which the LCE counts against its credit pool until acknowledged, the block itself issues the e_bedrock_cmd_uc_st_done LCE command that returns the credit.

---
 rtl/bp_cce_lce_req_receiver_pkg.sv | 107 ++++++++++
 rtl/bp_cce_lce_req_receiver_fifo.sv | 60 ++++++
 rtl/bp_cce_lce_req_receiver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bp_cce_lce_req_receiver_pkg.sv
// Shared types for the CCE-side LCE request receiver: BedRock LCE request/command
// message layouts for the default config, the decoded request type and the ack FSM state.
package bp_cce_lce_req_receiver_pkg;

    localparam int paddr_width_p     = 40;
    localparam int lce_id_width_p    = 4;
    localparam int cce_id_width_p    = 6;
    localparam int lce_assoc_p       = 8;
    localparam int cce_block_width_p = 512;
    localparam int dword_width_gp    = 64;
    localparam int lg_lce_assoc_lp   = $clog2(lce_assoc_p);

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1  = 3'd0,
        e_bedrock_msg_size_2  = 3'd1,
        e_bedrock_msg_size_4  = 3'd2,
        e_bedrock_msg_size_8  = 3'd3,
        e_bedrock_msg_size_16 = 3'd4,
        e_bedrock_msg_size_32 = 3'd5,
        e_bedrock_msg_size_64 = 3'd6
    } bp_bedrock_msg_size_e;

    typedef enum logic [3:0] {
        e_bedrock_req_rd_miss = 4'd0,
        e_bedrock_req_wr_miss = 4'd1,
        e_bedrock_req_uc_rd   = 4'd2,
        e_bedrock_req_uc_wr   = 4'd3,
        e_bedrock_req_uc_amo  = 4'd4
    } bp_bedrock_req_type_e;

    typedef enum logic [3:0] {
        e_bedrock_cmd_sync       = 4'd0,
        e_bedrock_cmd_set_clear  = 4'd1,
        e_bedrock_cmd_inv        = 4'd2,
        e_bedrock_cmd_st         = 4'd3,
        e_bedrock_cmd_data       = 4'd4,
        e_bedrock_cmd_st_wakeup  = 4'd5,
        e_bedrock_cmd_wb         = 4'd6,
        e_bedrock_cmd_st_wb      = 4'd7,
        e_bedrock_cmd_tr         = 4'd8,
        e_bedrock_cmd_st_tr      = 4'd9,
        e_bedrock_cmd_st_tr_wb   = 4'd10,
        e_bedrock_cmd_uc_data    = 4'd11,
        e_bedrock_cmd_uc_st_done = 4'd12
    } bp_bedrock_cmd_type_e;

    typedef struct packed {
        logic [cce_id_width_p-1:0]  dst_id;
        logic [lce_id_width_p-1:0]  src_id;
        logic [lg_lce_assoc_lp-1:0] lru_way_id;
        logic                       non_exclusive;
    } bp_bedrock_lce_req_payload_s;

    typedef struct packed {
        logic [3:0]                  msg_type;
        logic [paddr_width_p-1:0]    addr;
        logic [2:0]                  size;
        bp_bedrock_lce_req_payload_s payload;
    } bp_bedrock_lce_req_header_s;

    typedef struct packed {
        bp_bedrock_lce_req_header_s   header;
        logic [cce_block_width_p-1:0] data;
    } bp_bedrock_lce_req_msg_s;

    typedef struct packed {
        logic [lce_id_width_p-1:0]  dst_id;
        logic [cce_id_width_p-1:0]  src_id;
        logic [lg_lce_assoc_lp-1:0] way_id;
        logic [2:0]                 state;
        logic [lce_id_width_p-1:0]  target;
        logic [lg_lce_assoc_lp-1:0] target_way_id;
    } bp_bedrock_lce_cmd_payload_s;

    typedef struct packed {
        logic [3:0]                  msg_type;
        logic [paddr_width_p-1:0]    addr;
        logic [2:0]                  size;
        bp_bedrock_lce_cmd_payload_s payload;
    } bp_bedrock_lce_cmd_header_s;

    typedef struct packed {
        bp_bedrock_lce_cmd_header_s   header;
        logic [cce_block_width_p-1:0] data;
    } bp_bedrock_lce_cmd_msg_s;

    localparam int lce_req_msg_width_lp = $bits(bp_bedrock_lce_req_msg_s);
    localparam int lce_cmd_msg_width_lp = $bits(bp_bedrock_lce_cmd_msg_s);

    typedef enum logic [1:0] {
        e_cce_req_rd    = 2'd0,
        e_cce_req_wr    = 2'd1,
        e_cce_req_uc_rd = 2'd2,
        e_cce_req_uc_wr = 2'd3
    } bp_cce_req_type_e;

    typedef enum logic {
        e_ready       = 1'b0,
        e_send_uc_ack = 1'b1
    } bp_cce_lce_req_state_e;

    // Only the four request types the CCE core understands map onto req_type_o.
    function automatic logic is_supported_req(input logic [3:0] msg_type);
        return (msg_type[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/bp_cce_lce_req_receiver_fifo.sv
// Small 1-read/1-write FIFO with asynchronously reset pointers; the storage itself
// is not reset since nothing reads an entry before it has been written.
module bp_cce_lce_req_receiver_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2,
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      v_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      yumi_i,
    output logic [count_width_lp-1:0] count_o
);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq, deq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
        return (ptr == ptr_width_lp'(els_p - 1)) ? '0 : ptr + ptr_width_lp'(1);
    endfunction

    assign ready_o = (count_q != count_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        wptr_d  = enq ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = deq ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q + count_width_lp'(enq) - count_width_lp'(deq);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_cce_lce_req_receiver.sv
// CCE-side consumer of the LCE request channel: buffers, route-checks and decodes
// requests for the CCE core, and returns uncached-store credits with uc_st_done.
module bp_cce_lce_req_receiver
    import bp_cce_lce_req_receiver_pkg::*;
#(
    parameter int buf_els_p = 2,
    localparam int pending_width_lp = $clog2(buf_els_p + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [cce_id_width_p-1:0]                cce_id_i,
    input  logic [lce_req_msg_width_lp-1:0]          lce_req_i,
    input  logic                                     lce_req_v_i,
    output logic                                     lce_req_ready_then_o,
    output logic                                     req_v_o,
    input  logic                                     req_yumi_i,
    output logic [1:0]                               req_type_o,
    output logic [lce_id_width_p-1:0]                req_lce_id_o,
    output logic [paddr_width_p-1:0]                 req_addr_o,
    output logic [$bits(bp_bedrock_msg_size_e)-1:0]  req_size_o,
    output logic [lg_lce_assoc_lp-1:0]               req_lru_way_o,
    output logic                                     req_non_excl_o,
    output logic [dword_width_gp-1:0]                req_data_o,
    output logic [lce_cmd_msg_width_lp-1:0]          lce_cmd_o,
    output logic                                     lce_cmd_v_o,
    input  logic                                     lce_cmd_ready_then_i,
    output logic                                     error_o,
    output logic [pending_width_lp-1:0]              pending_o
);

    bp_cce_lce_req_state_e          state_q, state_d;
    logic [lce_id_width_p-1:0]      ack_lce_id_q, ack_lce_id_d;
    logic [paddr_width_p-1:0]       ack_addr_q, ack_addr_d;
    logic [2:0]                     ack_size_q, ack_size_d;
    logic                           error_q, error_d;

    logic                           fifo_ready, fifo_v, fifo_yumi;
    logic [lce_req_msg_width_lp-1:0] fifo_data;
    bp_bedrock_lce_req_msg_s        head;
    bp_bedrock_lce_cmd_msg_s        cmd;
    logic                           head_legal, head_drop, head_yumi;
    logic                           unused_head_data;

    bp_cce_lce_req_receiver_fifo #(
        .width_p(lce_req_msg_width_lp),
        .els_p  (buf_els_p)
    ) req_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .data_i (lce_req_i),
        .v_i    (lce_req_v_i),
        .ready_o(fifo_ready),
        .v_o    (fifo_v),
        .data_o (fifo_data),
        .yumi_i (fifo_yumi),
        .count_o(pending_o)
    );

    assign head             = fifo_data;
    assign unused_head_data = ^head.data[cce_block_width_p-1:dword_width_gp];

    // Misrouted or unsupported heads are silently drained so they never block the queue.
    assign head_legal = (head.header.payload.dst_id == cce_id_i)
                      & is_supported_req(head.header.msg_type);
    assign head_drop  = fifo_v & ~head_legal;
    assign req_v_o    = fifo_v & head_legal & (state_q == e_ready);
    assign head_yumi  = req_v_o & req_yumi_i;
    assign fifo_yumi  = head_drop | head_yumi;

    assign lce_req_ready_then_o = fifo_ready & ~reset_i;
    assign error_o              = error_q;
    assign lce_cmd_v_o          = (state_q == e_send_uc_ack) & lce_cmd_ready_then_i;
    assign lce_cmd_o            = cmd;

    assign req_type_o     = req_v_o ? head.header.msg_type[1:0] : '0;
    assign req_lce_id_o   = req_v_o ? head.header.payload.src_id : '0;
    assign req_addr_o     = req_v_o ? head.header.addr : '0;
    assign req_size_o     = req_v_o ? head.header.size : '0;
    assign req_lru_way_o  = req_v_o ? head.header.payload.lru_way_id : '0;
    assign req_non_excl_o = req_v_o & head.header.payload.non_exclusive;
    assign req_data_o     = req_v_o ? head.data[dword_width_gp-1:0] : '0;

    always_comb begin
        cmd = '0;
        if (state_q == e_send_uc_ack) begin
            cmd.header.msg_type       = e_bedrock_cmd_uc_st_done;
            cmd.header.addr           = ack_addr_q;
            cmd.header.size           = ack_size_q;
            cmd.header.payload.dst_id = ack_lce_id_q;
            cmd.header.payload.src_id = cce_id_i;
        end
    end

    // The ack fields are latched at yumi time because the request leaves the buffer then.
    always_comb begin
        state_d      = state_q;
        ack_lce_id_d = ack_lce_id_q;
        ack_addr_d   = ack_addr_q;
        ack_size_d   = ack_size_q;
        error_d      = error_q | head_drop;
        case (state_q)
            e_ready: begin
                if (head_yumi && (head.header.msg_type[1:0] == e_cce_req_uc_wr)) begin
                    ack_lce_id_d = head.header.payload.src_id;
                    ack_addr_d   = head.header.addr;
                    ack_size_d   = head.header.size;
                    state_d      = e_send_uc_ack;
                end
            end
            e_send_uc_ack: begin
                if (lce_cmd_ready_then_i) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= e_ready;
            ack_lce_id_q <= '0;
            ack_addr_q   <= '0;
            ack_size_q   <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_lce_id_q <= ack_lce_id_d;
            ack_addr_q   <= ack_addr_d;
            ack_size_q   <= ack_size_d;
            error_q      <= error_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (reset_i) lce_req_v_i |-> lce_req_ready_then_o);
    assert property (@(posedge clk_i) disable iff (reset_i) req_yumi_i |-> req_v_o);

endmodule
